serial_chunk_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 14 +
 rtl/chunk_adder.sv | 14 +
 rtl/serial_chunk_adder.sv | 108 ++++++++++
 tb/tb_serial_chunk_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the serial chunk adder (state encoding, chunk count).
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice used once per cycle by serial_chunk_adder.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting A + ~B + 1.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out
);

    localparam int N     = chunk_count(WIDTH, CHUNK);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [CHUNK-1:0]   s;
    logic               co;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_q[idx*CHUNK +: CHUNK]),
        .b  (b_q[idx*CHUNK +: CHUNK]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        acc_next = acc;
        acc_next[idx*CHUNK +: CHUNK] = s;
    end

    // NOTE: gating with rst_n keeps in_ready low during reset yet high on the very first edge after release.
    assign in_ready = (state == IDLE) && rst_n;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= A;
`ifdef SERIAL_ADDER_SUB_EN
                        b_q   <= sub ? ~B : B;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_q   <= B;
                        carry <= cin;
`endif
                        idx   <= '0;
                        acc   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc   <= acc_next;
                    carry <= co;
                    if (idx == IDX_W'(N - 1)) begin
                        out       <= {co, acc_next};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: vector table + scoreboard on a 16/4 instance, N=1 case on an 8/8 instance.
module tb_serial_chunk_adder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, cin;
    logic [15:0] a_s, b_s;
    logic [16:0] out;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub_s;
    logic        sub8;
`endif

    logic        in8_valid, in8_ready, out8_valid, out8_ready, cin8;
    logic [7:0]  a8, b8;
    logic [8:0]  out8;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_s), .B(b_s), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready),
        .A(a8), .B(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(out8_valid), .out_ready(out8_ready), .out(out8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] exp;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        int          acc_cyc;
    } sb_t;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    sb_t  sb[$];
    int   rise_q[$];
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: latency on the rising edge of out_valid, value on handshake.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            rise_q.push_back(cyc);
            if (sb.size() == 0) check("spurious_result", 1, 0);
            else check("latency", 64'(cyc - sb[0].acc_cyc), 64'(N));
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            sb_t item;
            item = sb.pop_front();
            check("sum", 64'(out), 64'(item.exp));
        end
        prev_valid <= out_valid;
    end

    task automatic send(input vec_t v, input bit push);
        int t = 0;
        in_valid = 1'b1;
        a_s = v.a;
        b_s = v.b;
        cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub_s = v.sub;
`endif
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (push) sb.push_back('{v.exp, cyc});
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the running operation must not see them.
        a_s = 16'($urandom);
        b_s = 16'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 64'(sb.size()), 0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a_s = '0; b_s = '0; cin = 1'b0;
        in8_valid = 1'b0; out8_ready = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_s = 1'b0;
        sub8 = 1'b0;
`endif

        vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b0, 1'b0, 17'h1FFFD});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b1, 1'b0, 17'h00101});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000});
        vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 17'h0BCDF});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 17'h0FFFE});
        vecs.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 17'h10002});
`endif
        for (int i = 0; i < 6; i++) begin
            v.a = 16'($urandom);
            v.b = 16'($urandom);
            v.cin = 1'($urandom);
            v.sub = 1'b0;
            v.exp = {1'b0, v.a} + {1'b0, v.b} + {16'b0, v.cin};
            vecs.push_back(v);
        end

        #2;
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_out", 64'(out), 0);
        check("reset_in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i], 1'b1);
            drain("vector_drain");
        end

        // Back-to-back: in_valid effectively held high across three operations.
        rise_q.delete();
        for (int i = 0; i < 3; i++) send(vecs[i + 1], 1'b1);
        drain("b2b_drain");
        check("b2b_count", 64'(rise_q.size()), 3);
        if (rise_q.size() == 3) begin
            check("b2b_spacing0", 64'(rise_q[1] - rise_q[0]), N + 2);
            check("b2b_spacing1", 64'(rise_q[2] - rise_q[1]), N + 2);
        end

        // Backpressure: hold result for 10 cycles while new operands are offered.
        out_ready = 1'b0;
        send(vecs[0], 1'b1);
        for (int t = 0; t < 20 && !out_valid; t++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_rise", 64'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_s = 16'($urandom);
            b_s = 16'($urandom);
            @(posedge clk); #1;
            check("bp_valid_hold", 64'(out_valid), 1);
            check("bp_out_hold", 64'(out), 64'(17'h1FFFD));
            check("bp_in_ready", 64'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp_drain");
        @(posedge clk); #1;
        check("bp_released", 64'(out_valid), 0);

        // Reset mid-ADD aborts; the result register must clear immediately.
        send(vecs[4], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 0);
        check("midreset_out", 64'(out), 0);
        check("midreset_in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midreset_in_ready_release", 64'(in_ready), 1);
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_result", 64'(out_valid), 0);
        send(vecs[5], 1'b1);
        drain("recover_drain");

        // Single-chunk instance: result one cycle after accept.
        a8 = 8'h1E; b8 = 8'h1F; cin8 = 1'b0; in8_valid = 1'b1;
        #1;
        check("w8_in_ready", 64'(in8_ready), 1);
        @(posedge clk); #1;
        in8_valid = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF;
        check("w8_not_yet", 64'(out8_valid), 0);
        @(posedge clk); #1;
        check("w8_valid", 64'(out8_valid), 1);
        check("w8_sum", 64'(out8), 64'(9'h03D));
        @(posedge clk); #1;
        check("w8_idle", 64'(out8_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
